fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

- Fetch-stage program counter generator for the pipelined RV32I core.
- Holds PCF, computes next-PC each cycle, and consumes resolved branch/jump outcomes from the execute stage (branch unit `BranchTaken`, ALU target).
- Generates the front-end flushes on misprediction.
- Optionally predicts conditional branches with a tagged branch target buffer (BTB) plus 2-bit saturating counters.

## Interface
- DATA_WIDTH, 32, address/PC width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2
- clk_i  in  1  core clock, rising edge
- rst_ni  in  1  reset; one clock, asynchronous, active-low
- Stall_i  in  1  hazard unit freezes fetch (PC holds)
- BranchE_i  in  1  EX holds a valid conditional branch; one-cycle pulse per instruction
- BranchTakenE_i  in  1  branch outcome from branch unit
- JumpE_i  in  1  EX holds a valid JAL/JALR
- PredTakenE_i  in  1  prediction bit piped down with the EX instruction
- PCE_i  in  DATA_WIDTH  PC of the EX instruction
- TargetE_i  in  DATA_WIDTH  resolved branch/jump target
- PCF_o  out  DATA_WIDTH  current fetch PC (registered)
- PredTakenF_o  out  1  prediction for PCF_o, piped to decode
- FlushD_o  out  1  clear IF/ID register
- FlushE_o  out  1  clear ID/EX register

## Operation
- **Redirect detection (EX):**
  - Redirect = JumpE_i | (BranchE_i & (BranchTakenE_i != PredTakenE_i)).
  - Redirect target:
    - TargetE_i when JumpE_i, or when BranchE_i & BranchTakenE_i.
    - Otherwise PCE_i+4.
- **Next-PC priority:**
  1. Redirect.
  2. Stall_i (hold).
  3. BTB hit & predict taken → BTB target.
  4. PCF+4.
- Redirect overrides Stall_i.
- PC arithmetic is modulo 2^DATA_WIDTH: 0xFFFF_FFFC+4 = 0x0.
- PC bits [1:0] are forced to 00 on every load, including RESET_PC and targets.
- FlushD_o = FlushE_o = Redirect.
- **BTB (when enabled):**
  - Direct-mapped; index = PC[log2(BTB_ENTRIES)+1:2]; tag = remaining upper bits (full tag, no aliasing).
  - Entry fields: valid, tag, target, 2-bit counter.
  - Lookup on PCF_o.
  - Hit = valid & tag match; PredTakenF_o = hit & counter[1].
  - Update on BranchE_i, indexed by PCE_i:
    - Hit: counter += 1 if taken (saturates at 3), -= 1 if not taken (saturates at 0); target rewritten.
    - Miss & taken: allocate with valid=1, tag, target=TargetE_i, counter=2.
    - Miss & not taken: no change.
  - Jumps are never allocated.
- Simultaneous lookup and update on the same index: lookup returns pre-update contents; the update is visible the following cycle.
- **Reset (asynchronous, during any activity):**
  - PCF_o=RESET_PC.
  - All BTB valid bits and counters cleared to 0.
  - PredTakenF_o=0.
  - FlushD_o and FlushE_o are forced to 0 while rst_ni is low.
  - First PC increment occurs on the first rising edge after rst_ni rises.

## Timing
- PCF_o is registered; it updates on the rising edge after the decision cycle.
- PredTakenF_o, FlushD_o and FlushE_o are combinational:
  - PredTakenF_o from PCF_o and BTB state.
  - FlushD_o / FlushE_o from EX inputs.
- Redirect latency: Redirect in cycle n → PCF_o = target in cycle n+1; the flushes are asserted in cycle n.
- Misprediction penalty is 2 cycles (wrong-path instructions in F and D discarded).
- Correctly predicted taken branch: 0-cycle penalty, no flush.
- BTB update is written on the edge ending the BranchE_i cycle.
- BTB read path: combinational from flop storage; no RAM macro.

## Configuration
- Macro: `FETCH_BTB_PRED_EN`.
- **Defined:** BTB and counters are built as described above.
- **Undefined:**
  - No BTB storage; PredTakenF_o is tied 0.
  - Next-PC is redirect / hold / PCF+4 only.
  - Every taken branch and every jump redirects with a 2-cycle penalty.
  - Ports are unchanged.

## Test plan
- **Reset:** assert rst_ni low mid-stream at PCF=0x28 between clock edges → PCF_o=RESET_PC immediately, flushes 0; after release, PCF sequence is 0x0, 0x4, 0x8. With the BTB, a previously trained PC (0x10) then shows PredTakenF_o=0.
- **Sequential/stall:** no branches → PCF 0x0, 0x4, 0x8; Stall_i=1 for 2 cycles at 0x8 → holds 0x8, then 0xC.
- **Unpredicted taken branch:** BranchE_i=1, BranchTakenE_i=1, PredTakenE_i=0, PCE=0x10, TargetE=0x40, with Stall_i=1 in the same cycle → FlushD_o=FlushE_o=1 that cycle; PCF_o=0x40 next cycle.
- **(FETCH_BTB_PRED_EN) trained prediction:** after the scenario above, fetching 0x10 → PredTakenF_o=1, next PCF=0x40. Same branch resolves taken with PredTakenE_i=1 → no flush; counter reaches 3.
- **(FETCH_BTB_PRED_EN) predicted taken, resolves not taken:** PCE=0x10, counter=2 → flush, PCF_o=0x14 next cycle, counter=1; next fetch of 0x10 gives PredTakenF_o=0.
- **JALR and wrap:**
  - JumpE_i=1, TargetE=0x103 → PCF_o=0x100 next cycle, flushes asserted, no BTB allocation.
  - Separately, PCF=0xFFFF_FFFC with no events → PCF=0x0.

Source files
------------

// File: rtl/fetch_pc_unit_if.sv
// Fetch/execute boundary bundle for fetch_pc_unit.
// The pipeline side uses the master modport and the PC unit uses the slave modport.
interface fetch_pc_unit_if #(
  parameter int DATA_WIDTH = 32
);
  // There is no valid/ready handshake on this bundle.
  // The EX-side fields are meaningful only in a cycle where BranchE_i or JumpE_i is high.
  // Outputs are valid every cycle: PCF_o is registered; PredTakenF_o and the flushes are combinational.
  logic                  Stall_i;
  logic                  BranchE_i;
  logic                  BranchTakenE_i;
  logic                  JumpE_i;
  logic                  PredTakenE_i;
  logic [DATA_WIDTH-1:0] PCE_i;
  logic [DATA_WIDTH-1:0] TargetE_i;
  logic [DATA_WIDTH-1:0] PCF_o;
  logic                  PredTakenF_o;
  logic                  FlushD_o;
  logic                  FlushE_o;

  modport master (
    output Stall_i, BranchE_i, BranchTakenE_i, JumpE_i, PredTakenE_i, PCE_i, TargetE_i,
    input  PCF_o, PredTakenF_o, FlushD_o, FlushE_o
  );

  modport slave (
    input  Stall_i, BranchE_i, BranchTakenE_i, JumpE_i, PredTakenE_i, PCE_i, TargetE_i,
    output PCF_o, PredTakenF_o, FlushD_o, FlushE_o
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator with EX-resolved redirects and front-end flushes.
// Define FETCH_BTB_PRED_EN to build the direct-mapped BTB with 2-bit counters.
module fetch_pc_unit #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
  parameter int                    BTB_ENTRIES = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  fetch_pc_unit_if.slave bus
);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);

  logic [DATA_WIDTH-1:0] pcf_q;
  logic [DATA_WIDTH-1:0] pc_sel;
  logic [DATA_WIDTH-1:0] redirect_target;
  logic                  redirect;
  logic                  take_target;
  logic                  btb_pred;
  logic [DATA_WIDTH-1:0] btb_pred_target;

  always_comb begin
    redirect        = bus.JumpE_i | (bus.BranchE_i & (bus.BranchTakenE_i != bus.PredTakenE_i));
    take_target     = bus.JumpE_i | (bus.BranchE_i & bus.BranchTakenE_i);
    redirect_target = take_target ? bus.TargetE_i : (bus.PCE_i + PC_STEP);
    // A redirect beats a stall: the stalled instruction is on the wrong path.
    if (redirect)         pc_sel = redirect_target;
    else if (bus.Stall_i) pc_sel = pcf_q;
    else if (btb_pred)    pc_sel = btb_pred_target;
    else                  pc_sel = pcf_q + PC_STEP;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pcf_q <= RESET_PC & ALIGN_MASK;
    else         pcf_q <= pc_sel & ALIGN_MASK;
  end

  assign bus.PCF_o        = pcf_q;
  assign bus.PredTakenF_o = btb_pred;
  assign bus.FlushD_o     = redirect & rst_ni;
  assign bus.FlushE_o     = redirect & rst_ni;

`ifdef FETCH_BTB_PRED_EN
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

  logic                  btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0]      btb_tag    [BTB_ENTRIES];
  logic [DATA_WIDTH-1:0] btb_target [BTB_ENTRIES];
  logic [1:0]            btb_ctr    [BTB_ENTRIES];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_hit;

  always_comb begin
    rd_idx          = pcf_q[IDX_W+1:2];
    rd_tag          = pcf_q[DATA_WIDTH-1:IDX_W+2];
    wr_idx          = bus.PCE_i[IDX_W+1:2];
    wr_tag          = bus.PCE_i[DATA_WIDTH-1:IDX_W+2];
    wr_hit          = btb_valid[wr_idx] && (btb_tag[wr_idx] == wr_tag);
    btb_pred        = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag) && btb_ctr[rd_idx][1];
    btb_pred_target = btb_target[rd_idx];
  end

  // Written at the end of the BranchE_i cycle, so a same-index lookup sees old contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
        btb_ctr[i]    <= 2'd0;
      end
    end else if (bus.BranchE_i) begin
      if (wr_hit) begin
        btb_target[wr_idx] <= bus.TargetE_i & ALIGN_MASK;
        if (bus.BranchTakenE_i && (btb_ctr[wr_idx] != 2'd3))
          btb_ctr[wr_idx] <= btb_ctr[wr_idx] + 2'd1;
        else if (!bus.BranchTakenE_i && (btb_ctr[wr_idx] != 2'd0))
          btb_ctr[wr_idx] <= btb_ctr[wr_idx] - 2'd1;
      end else if (bus.BranchTakenE_i) begin
        btb_valid[wr_idx]  <= 1'b1;
        btb_tag[wr_idx]    <= wr_tag;
        btb_target[wr_idx] <= bus.TargetE_i & ALIGN_MASK;
        btb_ctr[wr_idx]    <= 2'd2;
      end
    end
  end
`else
  assign btb_pred        = 1'b0;
  assign btb_pred_target = '0;
`endif
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized scoreboard bench for fetch_pc_unit against a behavioural fetch/BTB model.
// Follows the build's FETCH_BTB_PRED_EN setting.
module tb_fetch_pc_unit;
  localparam int          DW       = 32;
  localparam int          N        = 16;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BTB_PRED_EN
  localparam bit BTB_EN = 1'b1;
`else
  localparam bit BTB_EN = 1'b0;
`endif

  // Clock and reset.
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_pc_unit_if #(.DATA_WIDTH(DW)) bus();

  fetch_pc_unit #(.DATA_WIDTH(DW), .RESET_PC(RESET_PC), .BTB_ENTRIES(N)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: {PCF, PredTakenF, FlushD, FlushE}.
  logic [34:0] exp_q[$];
  logic [34:0] mon_e;
  bit          mon_en = 1'b0;

  // Reference model: fetch PC plus a table of branch PCs.
  // Each entry holds the branch PC, its target and a confidence counter.
  logic [31:0] m_pc;
  bit          m_valid [N];
  logic [31:0] m_bpc   [N];
  logic [31:0] m_btgt  [N];
  int          m_ctr   [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic bit model_pred(input logic [31:0] pc);
    int s;
    s = slot(pc);
    return BTB_EN && m_valid[s] && (m_bpc[s] == pc) && (m_ctr[s] >= 2);
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC & ~32'h3;
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0;
      m_bpc[i]   = '0;
      m_btgt[i]  = '0;
      m_ctr[i]   = 0;
    end
  endtask

  // One decision cycle.
  // It is called just after a rising edge and returns 1 time unit after the next rising edge.
  task automatic cyc(input bit st, input bit br, input bit tk, input bit jp, input bit pd,
                     input logic [31:0] pce, input logic [31:0] tgt);
    bit          redir;
    bit          pred;
    logic [31:0] nxt;
    int          s;
    bus.Stall_i        = st;
    bus.BranchE_i      = br;
    bus.BranchTakenE_i = tk;
    bus.JumpE_i        = jp;
    bus.PredTakenE_i   = pd;
    bus.PCE_i          = pce;
    bus.TargetE_i      = tgt;
    pred  = model_pred(m_pc);
    redir = jp || (br && (tk != pd));
    exp_q.push_back({m_pc, pred, redir, redir});
    if (redir)     nxt = (jp || (br && tk)) ? tgt : pce + 32'd4;
    else if (st)   nxt = m_pc;
    else if (pred) nxt = m_btgt[slot(m_pc)];
    else           nxt = m_pc + 32'd4;
    if (BTB_EN && br) begin
      s = slot(pce);
      if (m_valid[s] && (m_bpc[s] == (pce & ~32'h3))) begin
        m_btgt[s] = tgt & ~32'h3;
        if (tk && m_ctr[s] < 3)       m_ctr[s]++;
        else if (!tk && m_ctr[s] > 0) m_ctr[s]--;
      end else if (tk) begin
        m_valid[s] = 1'b1;
        m_bpc[s]   = pce & ~32'h3;
        m_btgt[s]  = tgt & ~32'h3;
        m_ctr[s]   = 2;
      end
    end
    @(posedge clk);
    m_pc = nxt & ~32'h3;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic jump_to(input logic [31:0] tgt);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0300, tgt);
  endtask

  // Monitor: compare the presented outputs mid-cycle.
  always @(negedge clk) begin
    if (mon_en && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("pcf",      bus.PCF_o,                  mon_e[34:3]);
      check("pred_f",   {31'b0, bus.PredTakenF_o},  {31'b0, mon_e[2]});
      check("flush_d",  {31'b0, bus.FlushD_o},      {31'b0, mon_e[1]});
      check("flush_e",  {31'b0, bus.FlushE_o},      {31'b0, mon_e[0]});
    end
  end

  logic [31:0] addr_set [6];

  initial begin
    addr_set = '{32'h10, 32'h20, 32'h50, 32'h90, 32'h24, 32'h14};
    bus.Stall_i = 1'b0; bus.BranchE_i = 1'b0; bus.BranchTakenE_i = 1'b0;
    bus.JumpE_i = 1'b1; bus.PredTakenE_i = 1'b0; bus.PCE_i = '0; bus.TargetE_i = 32'h40;
    model_reset();
    #1;
    check("reset_pcf",     bus.PCF_o,                 RESET_PC);
    check("reset_flushd",  {31'b0, bus.FlushD_o},     32'h0);
    check("reset_flushe",  {31'b0, bus.FlushE_o},     32'h0);
    check("reset_pred",    {31'b0, bus.PredTakenF_o}, 32'h0);
    bus.JumpE_i = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    mon_en = 1'b1;

    // Sequential fetch and stall.
    idle();                       check("seq_4", bus.PCF_o, 32'h4);
    idle();                       check("seq_8", bus.PCF_o, 32'h8);
    cyc(1, 0, 0, 0, 0, 0, 0);     check("stall_hold1", bus.PCF_o, 32'h8);
    cyc(1, 0, 0, 0, 0, 0, 0);     check("stall_hold2", bus.PCF_o, 32'h8);
    idle();                       check("after_stall", bus.PCF_o, 32'hC);
    idle();

    // Unpredicted taken branch, with a stall in the same cycle.
    cyc(1, 1, 1, 0, 0, 32'h10, 32'h40);
    check("branch_redirect", bus.PCF_o, 32'h40);

    // Trained prediction.
    jump_to(32'h10);
`ifdef FETCH_BTB_PRED_EN
    check("trained_pred", {31'b0, bus.PredTakenF_o}, 32'h1);
    idle();
    check("pred_target", bus.PCF_o, 32'h40);
`else
    idle();
    check("no_pred_seq", bus.PCF_o, 32'h14);
`endif
    cyc(0, 1, 1, 0, 1, 32'h10, 32'h40);
    // Predicted taken, resolves not taken twice: 3 -> 2 -> 1.
    cyc(0, 1, 0, 0, 1, 32'h10, 32'h40);
    check("mispredict_pc1", bus.PCF_o, 32'h14);
    cyc(0, 1, 0, 0, 1, 32'h10, 32'h40);
    check("mispredict_pc2", bus.PCF_o, 32'h14);
    jump_to(32'h10);
    check("weak_pred", {31'b0, bus.PredTakenF_o}, 32'h0);

    // JALR alignment and wrap-around.
    cyc(0, 0, 0, 1, 0, 32'h200, 32'h103);
    check("jalr_align", bus.PCF_o, 32'h100);
    jump_to(32'hFFFF_FFFC);
    idle();
    check("wrap", bus.PCF_o, 32'h0);

    // Retrain 0x10 to strongly taken, then reset mid-stream at 0x28.
    cyc(0, 1, 1, 0, 0, 32'h10, 32'h40);
    cyc(0, 1, 1, 0, 0, 32'h10, 32'h40);
    jump_to(32'h20);
    idle();
    idle();
    check("pre_reset", bus.PCF_o, 32'h28);
    #2;
    bus.JumpE_i = 1'b1; bus.TargetE_i = 32'h80;
    rst_n = 1'b0;
    #1;
    check("async_reset_pcf",    bus.PCF_o,             RESET_PC);
    check("async_reset_flushd", {31'b0, bus.FlushD_o}, 32'h0);
    check("async_reset_flushe", {31'b0, bus.FlushE_o}, 32'h0);
    model_reset();
    bus.JumpE_i = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    idle();                       check("post_reset_4", bus.PCF_o, 32'h4);
    idle();                       check("post_reset_8", bus.PCF_o, 32'h8);
    idle();
    idle();
    check("post_reset_pc10",   bus.PCF_o,                 32'h10);
    check("post_reset_pred10", {31'b0, bus.PredTakenF_o}, 32'h0);

    // Randomized traffic over a small address pool to provoke hits, aliasing and evictions.
    for (int i = 0; i < 400; i++) begin
      bit          st, br, tk, jp, pd;
      logic [31:0] pce, tgt;
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 2) == 0);
      jp  = !br && ($urandom_range(0, 9) == 0);
      tk  = $urandom_range(0, 1);
      pd  = $urandom_range(0, 1);
      pce = addr_set[$urandom_range(0, 5)] | 32'($urandom_range(0, 3));
      tgt = addr_set[$urandom_range(0, 5)] | 32'($urandom_range(0, 3));
      cyc(st, br, tk, jp, pd, pce, tgt);
    end

    @(negedge clk);
    #1;
    check("queue_drain", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
